// File: rtl/karatsuba_mult_pipe.sv
// ----------------------------------------------------------------------------
// karatsuba_mult_pipe
//   Fully pipelined unsigned W x W -> 2W multiplier built on pairwise Karatsuba.
//   Operands are split into N = W/L limbs. The diagonal products are
//   Pii = Xi*Yi, and each cross term is Mij = (Xi+Xj)(Yi+Yj) - Pii - Pjj.
//   All terms are summed into limb columns and then carry-resolved, CG limbs
//   per stage. One operand pair can be accepted per cycle, and the whole
//   pipeline stalls together under output backpressure.
//
//   Latency from accept to out_valid is 4 + 2N/CG cycles.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   operand handshake (in_ready = !out_valid || out_ready)
//   X, Y                  W-bit operands
//   out_valid / out_ready product handshake
//   P                     2W-bit product, held stable while stalled
//   busy                  any stage, including the output, holds a valid entry
//   in_tag / out_tag      TAG_W-bit sideband that travels with the operands
//                         (present only when KMUL_TAG_EN is defined)
//
// Configuration macro: KMUL_TAG_EN
// ----------------------------------------------------------------------------
module karatsuba_mult_pipe #(
    parameter int unsigned W     = 256,
    parameter int unsigned L     = 64,
    parameter int unsigned CG    = 2,
    parameter int unsigned TAG_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     X,
    input  logic [W-1:0]     Y,
`ifdef KMUL_TAG_EN
    input  logic [TAG_W-1:0] in_tag,
    output logic [TAG_W-1:0] out_tag,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   P,
    output logic             busy
);

    localparam int unsigned N    = W / L;
    localparam int unsigned NP   = N * (N - 1) / 2;
    localparam int unsigned NCOL = 2 * N;
    localparam int unsigned NC   = NCOL / CG;
    localparam int unsigned NS   = 4 + NC;
    // A column holds at most N+2 terms below 2^(L+1).
    localparam int unsigned CW   = L + 2 + $clog2(N + 2);
    localparam int unsigned CYW  = CW - L + 1;

    if (W % L != 0) begin : g_err_wl
        $error("karatsuba_mult_pipe: W must be a multiple of L");
    end
    if (N < 2) begin : g_err_n
        $error("karatsuba_mult_pipe: W/L must be at least 2");
    end
    if ((2 * N) % CG != 0) begin : g_err_cg
        $error("karatsuba_mult_pipe: CG must divide 2*W/L");
    end
    if (TAG_W < 1) begin : g_err_tag
        $error("karatsuba_mult_pipe: TAG_W must be at least 1");
    end

    // Flat index of the cross pair (i, j), i > j.
    function automatic int unsigned pidx(input int unsigned i, input int unsigned j);
        return i * (i - 1) / 2 + j;
    endfunction

    logic          en;
    logic [NS-1:0] vld_q;

    assign en        = !out_valid || out_ready;
    assign in_ready  = en;
    assign out_valid = vld_q[NS-1];
    assign busy      = |vld_q;

    // S1: diagonal products and limb pair sums
    logic [2*L-1:0] s1_pd_d [N];
    logic [2*L-1:0] s1_pd   [N];
    logic [L:0]     s1_sx_d [NP];
    logic [L:0]     s1_sy_d [NP];
    logic [L:0]     s1_sx   [NP];
    logic [L:0]     s1_sy   [NP];

    always_comb begin
        s1_pd_d = '{default: '0};
        s1_sx_d = '{default: '0};
        s1_sy_d = '{default: '0};
        for (int unsigned i = 0; i < N; i++) begin
            s1_pd_d[i] = {{L{1'b0}}, X[i*L +: L]} * {{L{1'b0}}, Y[i*L +: L]};
        end
        for (int unsigned i = 1; i < N; i++) begin
            for (int unsigned j = 0; j < i; j++) begin
                s1_sx_d[pidx(i, j)] = {1'b0, X[i*L +: L]} + {1'b0, X[j*L +: L]};
                s1_sy_d[pidx(i, j)] = {1'b0, Y[i*L +: L]} + {1'b0, Y[j*L +: L]};
            end
        end
    end

    // S2: pair-sum products and diagonal pair sums.
    // Sij is kept modulo 2^(2L+1): its top bit always cancels against Pii+Pjj,
    // because the difference Mij is below 2^(2L+1).
    logic [2*L:0]   s2_s_d  [NP];
    logic [2*L:0]   s2_pp_d [NP];
    logic [2*L:0]   s2_s    [NP];
    logic [2*L:0]   s2_pp   [NP];
    logic [2*L-1:0] s2_pd   [N];

    always_comb begin
        s2_s_d  = '{default: '0};
        s2_pp_d = '{default: '0};
        for (int unsigned i = 1; i < N; i++) begin
            for (int unsigned j = 0; j < i; j++) begin
                s2_s_d[pidx(i, j)]  = {{L{1'b0}}, s1_sx[pidx(i, j)]} *
                                      {{L{1'b0}}, s1_sy[pidx(i, j)]};
                s2_pp_d[pidx(i, j)] = {1'b0, s1_pd[i]} + {1'b0, s1_pd[j]};
            end
        end
    end

    // S3: cross terms
    logic [2*L:0]   s3_m_d [NP];
    logic [2*L:0]   s3_m   [NP];
    logic [2*L-1:0] s3_pd  [N];

    always_comb begin
        s3_m_d = '{default: '0};
        for (int unsigned p = 0; p < NP; p++) begin
            s3_m_d[p] = s2_s[p] - s2_pp[p];
        end
    end

    // S4: limb column sums. Each term splits into a low limb at its offset and
    // a high part one column up.
    logic [CW-1:0] s4_col_d [NCOL];
    logic [CW-1:0] s4_col   [NCOL];

    always_comb begin
        s4_col_d = '{default: '0};
        for (int unsigned i = 0; i < N; i++) begin
            s4_col_d[2*i]   = s4_col_d[2*i]   + {{(CW-L){1'b0}}, s3_pd[i][L-1:0]};
            s4_col_d[2*i+1] = s4_col_d[2*i+1] + {{(CW-L){1'b0}}, s3_pd[i][2*L-1:L]};
        end
        for (int unsigned i = 1; i < N; i++) begin
            for (int unsigned j = 0; j < i; j++) begin
                s4_col_d[i+j]   = s4_col_d[i+j] +
                                  {{(CW-L){1'b0}}, s3_m[pidx(i, j)][L-1:0]};
                s4_col_d[i+j+1] = s4_col_d[i+j+1] +
                                  {{(CW-L-1){1'b0}}, s3_m[pidx(i, j)][2*L:L]};
            end
        end
    end

    // S5..: carry resolution. Stage s finalises limbs s*CG .. s*CG+CG-1.
    logic [CW-1:0]  cin_col  [NC][NCOL];
    logic [CYW-1:0] cin_cy   [NC];
    logic [2*W-1:0] cin_res  [NC];
    logic [CW-1:0]  cs_col_d [NC][NCOL];
    logic [CYW-1:0] cs_cy_d  [NC];
    logic [2*W-1:0] cs_res_d [NC];
    logic [CW-1:0]  cs_col   [NC][NCOL];
    logic [CYW-1:0] cs_cy    [NC];
    logic [2*W-1:0] cs_res   [NC];

    always_comb begin
        cin_col[0] = s4_col;
        cin_cy[0]  = '0;
        cin_res[0] = '0;
        for (int unsigned s = 1; s < NC; s++) begin
            cin_col[s] = cs_col[s-1];
            cin_cy[s]  = cs_cy[s-1];
            cin_res[s] = cs_res[s-1];
        end
    end

    always_comb begin
        logic [CW:0]    t;
        logic [CYW-1:0] cy;
        t        = '0;
        cy       = '0;
        cs_col_d = '{default: '0};
        cs_cy_d  = '{default: '0};
        cs_res_d = '{default: '0};
        for (int unsigned s = 0; s < NC; s++) begin
            cy          = cin_cy[s];
            cs_col_d[s] = cin_col[s];
            cs_res_d[s] = cin_res[s];
            for (int unsigned g = 0; g < CG; g++) begin
                t  = {1'b0, cin_col[s][s*CG+g]} + {{(CW+1-CYW){1'b0}}, cy};
                cs_res_d[s][(s*CG+g)*L +: L] = t[L-1:0];
                cy = t[CW:L];
            end
            cs_cy_d[s] = cy;
        end
    end

    assign P = cs_res[NC-1];

    // Control and the product register are reset; the rest of the datapath
    // is qualified by the valid chain and needs no reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_q  <= '0;
            cs_res <= '{default: '0};
        end else if (en) begin
            vld_q  <= {vld_q[NS-2:0], in_valid};
            cs_res <= cs_res_d;
        end
    end

    always_ff @(posedge clock) begin
        if (en) begin
            s1_pd  <= s1_pd_d;
            s1_sx  <= s1_sx_d;
            s1_sy  <= s1_sy_d;
            s2_s   <= s2_s_d;
            s2_pp  <= s2_pp_d;
            s2_pd  <= s1_pd;
            s3_m   <= s3_m_d;
            s3_pd  <= s2_pd;
            s4_col <= s4_col_d;
            cs_col <= cs_col_d;
            cs_cy  <= cs_cy_d;
        end
    end

`ifdef KMUL_TAG_EN
    logic [TAG_W-1:0] tag_q [NS];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tag_q <= '{default: '0};
        end else if (en) begin
            tag_q[0] <= in_tag;
            for (int unsigned s = 1; s < NS; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    assign out_tag = tag_q[NS-1];
`endif

endmodule

// File: tb/tb_karatsuba_mult_pipe.sv
// ----------------------------------------------------------------------------
// tb_karatsuba_mult_pipe
//   Directed bench for karatsuba_mult_pipe. Three instances:
//     dut   W=256 L=64 CG=2  (latency 8)
//     dut_b W=256 L=32 CG=4  (latency 8), shares the stimulus of dut
//     dut_c W=128 L=32 CG=1  (latency 12), fed only in the back-to-back test
// ----------------------------------------------------------------------------
module tb_karatsuba_mult_pipe;

    localparam int MAXG = 80;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_valid_c = 1'b0;
    logic         out_ready = 1'b1;
    logic         out_ready_c = 1'b1;
    logic [255:0] X = '0;
    logic [255:0] Y = '0;
    logic [7:0]   tag_in = '0;

    logic         in_ready, out_valid, busy;
    logic [511:0] P;
    logic         in_ready_b, out_valid_b, busy_b;
    logic [511:0] P_b;
    logic         in_ready_c, out_valid_c, busy_c;
    logic [255:0] P_c;
`ifdef KMUL_TAG_EN
    logic [7:0]   tag_out, tag_out_b, tag_out_c;
`endif

    int n_checks = 0;
    int n_bad = 0;

    logic [255:0] vx [64];
    logic [255:0] vy [64];
    int           acc_cyc [64];
    logic [511:0] got [MAXG];
    int           got_cyc [MAXG];
    logic [7:0]   got_tag [MAXG];
    int           n_got;
    logic [511:0] got_b [MAXG];
    int           got_b_cyc [MAXG];
    int           n_got_b;
    logic [255:0] got_c [MAXG];
    int           got_c_cyc [MAXG];
    int           n_got_c;
    logic         rec_ir [200];
    logic         rec_ov [200];
    logic [511:0] rec_p  [200];
    bit           c_on = 1'b0;
    int           hold = 0;

    always #5 clock = ~clock;

    karatsuba_mult_pipe #(.W(256), .L(64), .CG(2), .TAG_W(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .Y         (Y),
`ifdef KMUL_TAG_EN
        .in_tag    (tag_in),
        .out_tag   (tag_out),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .P         (P),
        .busy      (busy)
    );

    karatsuba_mult_pipe #(.W(256), .L(32), .CG(4), .TAG_W(8)) dut_b (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready_b),
        .X         (X),
        .Y         (Y),
`ifdef KMUL_TAG_EN
        .in_tag    (tag_in),
        .out_tag   (tag_out_b),
`endif
        .out_valid (out_valid_b),
        .out_ready (out_ready),
        .P         (P_b),
        .busy      (busy_b)
    );

    karatsuba_mult_pipe #(.W(128), .L(32), .CG(1), .TAG_W(8)) dut_c (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid_c),
        .in_ready  (in_ready_c),
        .X         (X[127:0]),
        .Y         (Y[127:0]),
`ifdef KMUL_TAG_EN
        .in_tag    (tag_in),
        .out_tag   (tag_out_c),
`endif
        .out_valid (out_valid_c),
        .out_ready (out_ready_c),
        .P         (P_c),
        .busy      (busy_c)
    );

    task automatic fill_random(input int n);
        for (int k = 0; k < n; k++) begin
            for (int w = 0; w < 8; w++) begin
                vx[k][w*32 +: 32] = $urandom();
                vy[k][w*32 +: 32] = $urandom();
            end
        end
    endtask

    // Drives n vectors from vx/vy and records what the DUTs do; no checking.
    // mode 0: out_ready=1, mode 1: random out_ready, mode 2: out_ready=0 before cycle 'hold'.
    task automatic stream(input int n, input int mode, input int budget);
        int idx;
        idx = 0;
        n_got = 0;
        n_got_b = 0;
        n_got_c = 0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            in_valid   = (idx < n);
            in_valid_c = c_on && (idx < n);
            if (idx < n) begin
                X      = vx[idx];
                Y      = vy[idx];
                tag_in = idx[7:0];
            end else begin
                X = '0;
                Y = '0;
            end
            case (mode)
                1:       out_ready = 1'($urandom_range(0, 1));
                2:       out_ready = (cyc >= hold);
                default: out_ready = 1'b1;
            endcase
            @(negedge clock);
            if (cyc < 200) begin
                rec_ir[cyc] = in_ready;
                rec_ov[cyc] = out_valid;
                rec_p[cyc]  = P;
            end
            if (in_valid && in_ready) begin
                acc_cyc[idx] = cyc;
                idx++;
            end
            if (out_valid && out_ready && n_got < MAXG) begin
                got[n_got]     = P;
                got_cyc[n_got] = cyc;
`ifdef KMUL_TAG_EN
                got_tag[n_got] = tag_out;
`endif
                n_got++;
            end
            if (out_valid_b && out_ready && n_got_b < MAXG) begin
                got_b[n_got_b]     = P_b;
                got_b_cyc[n_got_b] = cyc;
                n_got_b++;
            end
            if (out_valid_c && out_ready_c && n_got_c < MAXG) begin
                got_c[n_got_c]     = P_c;
                got_c_cyc[n_got_c] = cyc;
                n_got_c++;
            end
            @(posedge clock);
            #1;
        end
        in_valid   = 1'b0;
        in_valid_c = 1'b0;
        out_ready  = 1'b1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_busy got=%b want=0", busy);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
        n_checks++;
        if (P !== 512'd0) begin
            n_bad++; $display("FAIL reset_P got=%h want=0", P);
        end
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_single();
        vx[0] = 256'd3;
        vy[0] = 256'd5;
        stream(1, 0, 20);
        n_checks++;
        if (n_got !== 1) begin
            n_bad++; $display("FAIL single_count got=%0d want=1", n_got);
        end else begin
            n_checks++;
            if (got[0] !== 512'd15) begin
                n_bad++; $display("FAIL single_P got=%h want=15", got[0]);
            end
            n_checks++;
            if (got_cyc[0] - acc_cyc[0] !== 8) begin
                n_bad++; $display("FAIL single_latency got=%0d want=8", got_cyc[0] - acc_cyc[0]);
            end
        end
    endtask

    task automatic test_corners();
        logic [511:0] e [5];
        vx[0] = '1;               vy[0] = '1;
        vx[1] = '0;               vy[1] = '1;
        vx[2] = 256'd1 << 64;     vy[2] = 256'd1 << 64;
        vx[3] = 256'd1 << 255;    vy[3] = 256'd2;
        vx[4] = {64{1'b1}};       vy[4] = {64{1'b1}};
        e[0] = {{255{1'b1}}, {256{1'b0}}, 1'b1};
        e[1] = 512'd0;
        e[2] = 512'd1 << 128;
        e[3] = 512'd1 << 256;
        e[4] = (512'd1 << 128) - (512'd1 << 65) + 512'd1;
        stream(5, 0, 25);
        n_checks++;
        if (n_got !== 5) begin
            n_bad++; $display("FAIL corner_count got=%0d want=5", n_got);
        end
        n_checks++;
        if (n_got_b !== 5) begin
            n_bad++; $display("FAIL corner_count_b got=%0d want=5", n_got_b);
        end
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (got[k] !== e[k]) begin
                n_bad++; $display("FAIL corner_P[%0d] got=%h want=%h", k, got[k], e[k]);
            end
            n_checks++;
            if (got_b[k] !== e[k]) begin
                n_bad++; $display("FAIL corner_P_b[%0d] got=%h want=%h", k, got_b[k], e[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [511:0] m;
        logic [255:0] mc;
        fill_random(64);
        c_on = 1'b1;
        stream(64, 0, 90);
        c_on = 1'b0;
        n_checks++;
        if (n_got !== 64) begin
            n_bad++; $display("FAIL b2b_count got=%0d want=64", n_got);
        end
        n_checks++;
        if (n_got_b !== 64) begin
            n_bad++; $display("FAIL b2b_count_b got=%0d want=64", n_got_b);
        end
        n_checks++;
        if (n_got_c !== 64) begin
            n_bad++; $display("FAIL b2b_count_c got=%0d want=64", n_got_c);
        end
        for (int k = 0; k < 64; k++) begin
            m  = {256'd0, vx[k]} * {256'd0, vy[k]};
            mc = {128'd0, vx[k][127:0]} * {128'd0, vy[k][127:0]};
            n_checks++;
            if (acc_cyc[k] !== k) begin
                n_bad++; $display("FAIL b2b_accept[%0d] got=%0d want=%0d", k, acc_cyc[k], k);
            end
            n_checks++;
            if (got[k] !== m || got_cyc[k] !== k + 8) begin
                n_bad++; $display("FAIL b2b_P[%0d] got=%h@%0d want=%h@%0d", k, got[k],
                                  got_cyc[k], m, k + 8);
            end
            n_checks++;
            if (got_b[k] !== m || got_b_cyc[k] !== k + 8) begin
                n_bad++; $display("FAIL b2b_P_b[%0d] got=%h@%0d want=%h@%0d", k, got_b[k],
                                  got_b_cyc[k], m, k + 8);
            end
            n_checks++;
            if (got_c[k] !== mc || got_c_cyc[k] !== k + 12) begin
                n_bad++; $display("FAIL b2b_P_c[%0d] got=%h@%0d want=%h@%0d", k, got_c[k],
                                  got_c_cyc[k], mc, k + 12);
            end
        end
    endtask

    task automatic test_stall();
        logic [511:0] m;
        fill_random(12);
        hold = 18;
        stream(12, 2, 60);
        m = {256'd0, vx[0]} * {256'd0, vy[0]};
        for (int c = 8; c < 18; c++) begin
            n_checks++;
            if (rec_ir[c] !== 1'b0 || rec_ov[c] !== 1'b1 || rec_p[c] !== m) begin
                n_bad++; $display("FAIL stall_hold[%0d] got=ir%b ov%b %h want=ir0 ov1 %h", c,
                                  rec_ir[c], rec_ov[c], rec_p[c], m);
            end
        end
        n_checks++;
        if (acc_cyc[7] !== 7 || acc_cyc[8] !== 18) begin
            n_bad++; $display("FAIL stall_accept got=%0d,%0d want=7,18", acc_cyc[7], acc_cyc[8]);
        end
        n_checks++;
        if (n_got !== 12) begin
            n_bad++; $display("FAIL stall_count got=%0d want=12", n_got);
        end
        for (int k = 0; k < 12; k++) begin
            m = {256'd0, vx[k]} * {256'd0, vy[k]};
            n_checks++;
            if (got[k] !== m) begin
                n_bad++; $display("FAIL stall_P[%0d] got=%h want=%h", k, got[k], m);
            end
        end
    endtask

    task automatic test_reset_in_flight();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            X = 256'(k + 1);
            Y = 256'(k + 2);
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL flight_busy got=%b want=1", busy);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || busy_b !== 1'b0) begin
            n_bad++; $display("FAIL flight_reset got=ov%b busy%b busy_b%b want=0 0 0",
                              out_valid, busy, busy_b);
        end
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        vx[0] = 256'd7;
        vy[0] = 256'd9;
        stream(1, 0, 30);
        n_checks++;
        if (n_got !== 1 || got[0] !== 512'd63) begin
            n_bad++; $display("FAIL flight_after got=%0d results, first %h want=1 result 63",
                              n_got, got[0]);
        end
    endtask

    task automatic test_random_ready();
        logic [511:0] m;
        fill_random(20);
        stream(20, 1, 150);
        n_checks++;
        if (n_got !== 20 || n_got_b !== 20) begin
            n_bad++; $display("FAIL rand_count got=%0d,%0d want=20,20", n_got, n_got_b);
        end
        for (int k = 0; k < 20; k++) begin
            m = {256'd0, vx[k]} * {256'd0, vy[k]};
            n_checks++;
            if (got[k] !== m || got_b[k] !== m) begin
                n_bad++; $display("FAIL rand_P[%0d] got=%h / %h want=%h", k, got[k], got_b[k], m);
            end
        end
    endtask

`ifdef KMUL_TAG_EN
    task automatic test_tag();
        logic [511:0] m;
        fill_random(16);
        stream(16, 1, 150);
        n_checks++;
        if (n_got !== 16) begin
            n_bad++; $display("FAIL tag_count got=%0d want=16", n_got);
        end
        for (int k = 0; k < 16; k++) begin
            m = {256'd0, vx[k]} * {256'd0, vy[k]};
            n_checks++;
            if (got_tag[k] !== 8'(k) || got[k] !== m) begin
                n_bad++; $display("FAIL tag[%0d] got=%0d %h want=%0d %h", k, got_tag[k], got[k],
                                  k, m);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_corners();
        test_back_to_back();
        test_stall();
        test_reset_in_flight();
        test_random_ready();
`ifdef KMUL_TAG_EN
        test_tag();
`endif
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
